leb128_stream_decoder: RTL and testbench

Byte-serial LEB128 decoder. It accepts one encoded byte per cycle on a valid/ready stream, accumulates 7-bit chunks into a W-bit word, and emits one decoded value per terminating byte on a registered valid/ready output. Unsigned and signed (SLEB128) modes are supported. It is the streaming, parametrised successor to the 5-byte combinational u32 unpacker and sits between the byte-oriented bitstream reader and the field parsers.

---
 rtl/leb128_stream_decoder_if.sv | 23 ++
 rtl/leb128_stream_decoder.sv | 131 +++++++++++++
 tb/tb_leb128_stream_decoder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/leb128_stream_decoder_if.sv
// rtl/leb128_stream_decoder_if.sv - byte-in / value-out handshake bundle for the LEB128 decoder
interface leb128_stream_decoder_if #(
    parameter int W = 32
);
    logic [7:0]   i_data;
    logic         i_valid;
    logic         i_ready;
    logic [W-1:0] o_data;
    logic [3:0]   o_len;
    logic         o_err;
    logic         o_valid;
    logic         o_ready;

    modport master (
        output i_data, i_valid, o_ready,
        input  i_ready, o_data, o_len, o_err, o_valid
    );

    modport slave (
        input  i_data, i_valid, o_ready,
        output i_ready, o_data, o_len, o_err, o_valid
    );
endinterface

// File: rtl/leb128_stream_decoder.sv
// rtl/leb128_stream_decoder.sv - byte-serial LEB128/SLEB128 decoder; LEB128_OVERFLOW_CHECK_EN enables o_err
module leb128_stream_decoder #(
    parameter int W      = 32,
    parameter bit SIGNED = 1'b0
) (
    input logic                    clk,
    input logic                    rst,
    leb128_stream_decoder_if.slave bus
);
    localparam int         MAXB   = (W + 6) / 7;
    localparam logic [3:0] MAXB_L = 4'(MAXB);

    typedef enum logic [1:0] {IDLE, ACC, SKIP} state_t;

    state_t       state;
    logic [W-1:0] acc;
    logic [3:0]   k;
    logic         err;

    logic [W-1:0] o_data_r;
    logic [3:0]   o_len_r;
    logic         o_err_r;
    logic         o_valid_r;

    logic         accept;
    logic         cont;
    logic         in_skip;
    logic [6:0]   chunk;
    logic [3:0]   k_nxt;
    logic [W-1:0] placed;
    logic [W-1:0] acc_nxt;
    logic [W-1:0] ext_mask;
    logic [W-1:0] final_val;
    logic         byte_err;
    int           sh;
    int           sh_ext;

    assign bus.i_ready = ~o_valid_r | bus.o_ready;
    assign bus.o_data  = o_data_r;
    assign bus.o_len   = o_len_r;
    assign bus.o_err   = o_err_r;
    assign bus.o_valid = o_valid_r;

    assign accept  = bus.i_valid & bus.i_ready;
    assign cont    = bus.i_data[7];
    assign chunk   = bus.i_data[6:0];
    assign in_skip = (state == SKIP);

    always_comb begin
        sh        = 7 * int'(k);
        sh_ext    = 7 * (int'(k) + 1);
        k_nxt     = (k == 4'd15) ? k : k + 4'd1;
        // Chunk bits shifted past W-1 fall off the top of the word.
        placed    = {{(W-7){1'b0}}, chunk} << sh;
        acc_nxt   = in_skip ? acc : (acc | placed);
        // A shift of W or more yields zero, so no extension once the word is full.
        ext_mask  = {W{1'b1}} << sh_ext;
        final_val = acc_nxt;
        if (SIGNED && !in_skip && chunk[6]) begin
            final_val = acc_nxt | ext_mask;
        end
    end

`ifdef LEB128_OVERFLOW_CHECK_EN
    localparam int         REM     = W - 7 * (MAXB - 1);
    localparam logic [6:0] HI_MASK = 7'(7'h7F << REM);

    logic last_idx;
    assign last_idx = ~in_skip & (k == MAXB_L - 4'd1);

    always_comb begin
        byte_err = 1'b0;
        if (accept) begin
            if (in_skip) begin
                byte_err = 1'b1;
            end else if (last_idx) begin
                if (cont) begin
                    byte_err = 1'b1;
                end
                // Bits of the final chunk above W-1 must be zero, or copies of the sign bit.
                if (SIGNED) begin
                    if ((chunk & HI_MASK) != (chunk[REM-1] ? HI_MASK : 7'd0)) begin
                        byte_err = 1'b1;
                    end
                end else if ((chunk & HI_MASK) != 7'd0) begin
                    byte_err = 1'b1;
                end
            end
        end
    end
`else
    assign byte_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            k         <= '0;
            err       <= 1'b0;
            o_data_r  <= '0;
            o_len_r   <= '0;
            o_err_r   <= 1'b0;
            o_valid_r <= 1'b0;
        end else begin
            if (accept && cont) begin
                acc <= acc_nxt;
                k   <= k_nxt;
                err <= err | byte_err;
                if (in_skip || (k_nxt == MAXB_L)) begin
                    state <= SKIP;
                end else begin
                    state <= ACC;
                end
            end else if (accept) begin
                o_data_r  <= final_val;
                o_len_r   <= k_nxt;
                o_err_r   <= err | byte_err;
                o_valid_r <= 1'b1;
                acc       <= '0;
                k         <= '0;
                err       <= 1'b0;
                state     <= IDLE;
            end

            if (!(accept && !cont) && o_valid_r && bus.o_ready) begin
                o_valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_leb128_stream_decoder.sv
// tb/tb_leb128_stream_decoder.sv - unsigned and signed decoders fed one shared byte stream, checked against vectors and a model
module tb_leb128_stream_decoder;
    localparam int W    = 32;
    localparam int MAXB = (W + 6) / 7;
`ifdef LEB128_OVERFLOW_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       vin = 1'b0;
    logic       oready = 1'b0;
    logic       rand_on = 1'b0;

    always #5 clk = ~clk;

    leb128_stream_decoder_if #(.W(W)) bu ();
    leb128_stream_decoder_if #(.W(W)) bs ();

    assign bu.i_data  = din;
    assign bu.i_valid = vin;
    assign bu.o_ready = oready;
    assign bs.i_data  = din;
    assign bs.i_valid = vin;
    assign bs.o_ready = oready;

    leb128_stream_decoder #(.W(W), .SIGNED(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(bu));
    leb128_stream_decoder #(.W(W), .SIGNED(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bs));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic [3:0]   len;
        logic         err;
    } exp_t;

    // Decode from the arithmetic meaning of the encoding, not from any register view.
    function automatic exp_t model(input logic [7:0] b[$], input bit sgn);
        exp_t         e;
        int           n = b.size();
        int           m = (n < MAXB) ? n : MAXB;
        logic [127:0] raw = '0;
        bit           ovf;
        for (int i = 0; i < m; i++) begin
            raw = raw | (128'(b[i][6:0]) << (7 * i));
        end
        if (n <= MAXB) begin
            if (sgn && b[n-1][6]) raw = raw | (~128'd0 << (7 * n));
            if (sgn) ovf = ({{(128-W){raw[W-1]}}, raw[W-1:0]} != raw);
            else     ovf = ((raw >> W) != 128'd0);
        end else begin
            ovf = 1'b1;
        end
        e.data = raw[W-1:0];
        e.len  = (n > 15) ? 4'd15 : 4'(n);
        e.err  = CHK & ovf;
        return e;
    endfunction

    logic [7:0] bq[$];
    exp_t       equ[$];
    exp_t       eqs[$];
    int         npop = 0;

    always @(negedge clk) begin
        if (rst) begin
            bq.delete();
            equ.delete();
            eqs.delete();
        end else begin
            if (bu.o_valid && bu.o_ready) begin
                if (equ.size() == 0 || eqs.size() == 0) begin
                    chk("sb_unexpected_output", 1, 0);
                end else begin
                    exp_t eu;
                    exp_t es;
                    eu = equ.pop_front();
                    es = eqs.pop_front();
                    npop++;
                    chk("sb_u_data", bu.o_data, eu.data);
                    chk("sb_u_len", bu.o_len, eu.len);
                    chk("sb_u_err", bu.o_err, eu.err);
                    chk("sb_s_data", bs.o_data, es.data);
                    chk("sb_s_len", bs.o_len, es.len);
                    chk("sb_s_err", bs.o_err, es.err);
                end
            end
            if (vin && bu.i_ready) begin
                bq.push_back(din);
                if (!din[7]) begin
                    equ.push_back(model(bq, 1'b0));
                    eqs.push_back(model(bq, 1'b1));
                    bq.delete();
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        din = b;
        vin = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bu.i_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        vin = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          n;
        logic [63:0] b;
        logic [31:0] u;
        logic [31:0] s;
        logic [3:0]  len;
        logic        eu;
        logic        es;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1, 64'h02,           32'h00000002, 32'h00000002, 4'd1, 1'b0, 1'b0};
        tbl[1] = '{3, 64'h268EE5,       32'h00098765, 32'h00098765, 4'd3, 1'b0, 1'b0};
        tbl[2] = '{1, 64'h05,           32'h00000005, 32'h00000005, 4'd1, 1'b0, 1'b0};
        tbl[3] = '{1, 64'h7F,           32'h0000007F, 32'hFFFFFFFF, 4'd1, 1'b0, 1'b0};
        tbl[4] = '{3, 64'h78BBC0,       32'h001E1DC0, 32'hFFFE1DC0, 4'd3, 1'b0, 1'b0};
        tbl[5] = '{5, 64'h0FFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5, 1'b0, 1'b1};
        tbl[6] = '{5, 64'h1FFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5, 1'b1, 1'b1};
        tbl[7] = '{6, 64'h018080808080, 32'h00000000, 32'h00000000, 4'd6, 1'b1, 1'b1};
        tbl[8] = '{2, 64'h7F80,         32'h00003F80, 32'hFFFFFF80, 4'd2, 1'b0, 1'b0};

        #12;
        chk("rst_o_valid", bu.o_valid, 0);
        chk("rst_o_data", bu.o_data, 0);
        chk("rst_o_len", bu.o_len, 0);
        chk("rst_o_err", bu.o_err, 0);
        chk("rst_i_ready", bu.i_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        oready = 1'b1;

        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < tbl[i].n; j++) send_byte(tbl[i].b[8*j +: 8]);
            chk("tbl_valid", bu.o_valid, 1);
            chk("tbl_u_data", bu.o_data, tbl[i].u);
            chk("tbl_u_len", bu.o_len, tbl[i].len);
            chk("tbl_u_err", bu.o_err, CHK & tbl[i].eu);
            chk("tbl_s_data", bs.o_data, tbl[i].s);
            chk("tbl_s_err", bs.o_err, CHK & tbl[i].es);
        end

        for (int j = 0; j < 16; j++) send_byte(8'h80);
        send_byte(8'h00);
        chk("sat_len", bu.o_len, 15);
        chk("sat_data", bu.o_data, 0);
        chk("sat_err", bu.o_err, CHK);

        tick(1);
        chk("drain_valid", bu.o_valid, 0);
        oready = 1'b0;
        send_byte(8'h0A);
        din = 8'h0B;
        vin = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            chk("bp_i_ready", bu.i_ready, 0);
            chk("bp_o_valid", bu.o_valid, 1);
            chk("bp_o_data", bu.o_data, 32'h0A);
        end
        oready = 1'b1;
        send_byte(8'h0B);
        chk("bp_next_valid", bu.o_valid, 1);
        chk("bp_next_data", bu.o_data, 32'h0B);

        oready = 1'b0;
        tick(1);
        rst = 1'b1;
        #2;
        chk("rst_pending_dropped", bu.o_valid, 0);
        tick(1);
        rst = 1'b0;
        oready = 1'b1;
        send_byte(8'hE5);
        send_byte(8'h8E);
        rst = 1'b1;
        #2;
        chk("rst_mid_valid", bu.o_valid, 0);
        chk("rst_mid_data", bu.o_data, 0);
        chk("rst_mid_len", bu.o_len, 0);
        tick(1);
        rst = 1'b0;
        send_byte(8'h03);
        chk("post_rst_valid", bu.o_valid, 1);
        chk("post_rst_data", bu.o_data, 32'h3);
        chk("post_rst_len", bu.o_len, 1);
        tick(2);

        begin
            int base;
            base = npop;
            rand_on = 1'b1;
            fork
                begin
                    for (int v = 0; v < 300; v++) begin
                        int n;
                        n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 17)) : int'($urandom_range(1, 5));
                        for (int j = 0; j < n; j++) begin
                            logic [7:0] b;
                            b = 8'($urandom_range(0, 127));
                            if (j != n - 1) b[7] = 1'b1;
                            if ($urandom_range(0, 3) == 0) begin
                                vin = 1'b0;
                                tick($urandom_range(1, 2));
                            end
                            send_byte(b);
                        end
                    end
                    rand_on = 1'b0;
                end
                begin
                    while (rand_on) begin
                        tick(1);
                        oready = ($urandom_range(0, 3) != 0);
                    end
                end
            join
            oready = 1'b1;
            tick(5);
            chk("rand_outputs", npop - base, 300);
            chk("rand_u_queue_empty", equ.size(), 0);
            chk("rand_s_queue_empty", eqs.size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
